// File: rtl/regfile_rd_mux_if.sv
// Register-file access bundle: one write port plus NREAD packed read ports.
// The master drives the write and read requests. The slave is the register
// file, which returns the registered read data, the valid flags and werr.
interface regfile_rd_mux_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int NREAD = 2
);
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                    we;
  logic [ADDR_W-1:0]       waddr;
  logic [WIDTH-1:0]        wdata;
  logic [NREAD-1:0]        re;
  logic [NREAD*ADDR_W-1:0] raddr;
  logic [NREAD*WIDTH-1:0]  rdata;
  logic [NREAD-1:0]        rvalid;
  logic                    werr;

  modport master (
    output we, waddr, wdata, re, raddr,
    input  rdata, rvalid, werr
  );

  modport slave (
    input  we, waddr, wdata, re, raddr,
    output rdata, rvalid, werr
  );
endinterface

// File: rtl/regfile_rd_mux.sv
// Parametrised register file: DEPTH words of WIDTH bits, one synchronous write
// port and NREAD independent read ports. Each read port is registered, with a
// one-cycle latency, and has write-through bypass. Optionally, word 0 is
// hard-wired to zero. All outputs come directly from flops.
module regfile_rd_mux #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 16,
  parameter int NREAD   = 2,
  parameter int ZERO_R0 = 0
) (
  input  logic              clk,
  input  logic              reset,
  regfile_rd_mux_if.slave   bus
);
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_hit;
  logic             wr_ok;
  logic             wr_bad;
  logic             werr_p1;

  // An address is usable only if it lands inside the DEPTH words actually stored.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return int'(a) < DEPTH;
  endfunction

  // Word 0 counts as pinned only when the zero-register option is enabled.
  function automatic logic is_pinned(input logic [ADDR_W-1:0] a);
    return (ZERO_R0 != 0) && (a == '0);
  endfunction

  // Classify the write request: it either commits, is discarded on a pinned
  // word, or is an error.
  always_comb begin
    wr_hit = bus.we && in_range(bus.waddr);
    wr_ok  = wr_hit && !is_pinned(bus.waddr);
    wr_bad = bus.we && !in_range(bus.waddr);
  end

  // Storage update; reset clears every word.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < DEPTH; j++) mem[j] <= '0;
    end else if (wr_ok) begin
      mem[bus.waddr] <= bus.wdata;
    end
  end

  // werr is a single-cycle pulse that follows an out-of-range write.
  always_ff @(posedge clk) begin
    if (reset) werr_p1 <= 1'b0;
    else       werr_p1 <= wr_bad;
  end

  assign bus.werr = werr_p1;

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [WIDTH-1:0]  word;
    logic [WIDTH-1:0]  rdata_p1;
    logic              vld_p1;

    assign ra = bus.raddr[i*ADDR_W +: ADDR_W];

    // Select the word for this port. A committing write to the same address
    // takes precedence over storage. Out-of-range and pinned addresses read
    // as zero.
    always_comb begin
      word = '0;
      if (wr_ok && (ra == bus.waddr))
        word = bus.wdata;
      else if (in_range(ra) && !is_pinned(ra))
        word = mem[ra];
    end

    // ---- stage p1: registered read output; data holds while idle ----
    always_ff @(posedge clk) begin
      if (reset) begin
        rdata_p1 <= '0;
        vld_p1   <= 1'b0;
      end else begin
        vld_p1 <= bus.re[i];
        if (bus.re[i]) rdata_p1 <= word;
      end
    end

    assign bus.rdata[i*WIDTH +: WIDTH] = rdata_p1;
    assign bus.rvalid[i]               = vld_p1;
  end
endmodule

// File: tb/tb_regfile_rd_mux.sv
// Directed bench for regfile_rd_mux. It uses three instances: the default
// 16x16 file, a zero-register variant, and a 12-deep variant for the
// out-of-range cases.
module tb_regfile_rd_mux;
  logic clk = 1'b0;
  logic reset;
  int   passed = 0;
  int   failed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  regfile_rd_mux_if #(.WIDTH(16), .DEPTH(16), .NREAD(2)) bus_a ();
  regfile_rd_mux_if #(.WIDTH(16), .DEPTH(16), .NREAD(2)) bus_z ();
  regfile_rd_mux_if #(.WIDTH(16), .DEPTH(12), .NREAD(2)) bus_d ();

  regfile_rd_mux #(.WIDTH(16), .DEPTH(16), .NREAD(2), .ZERO_R0(0)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave));
  regfile_rd_mux #(.WIDTH(16), .DEPTH(16), .NREAD(2), .ZERO_R0(1)) dut_z (
    .clk(clk), .reset(reset), .bus(bus_z.slave));
  regfile_rd_mux #(.WIDTH(16), .DEPTH(12), .NREAD(2), .ZERO_R0(0)) dut_d (
    .clk(clk), .reset(reset), .bus(bus_d.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                       input logic [1:0] re, input logic [3:0] ra1, input logic [3:0] ra0);
    bus_a.we = we; bus_a.waddr = wa; bus_a.wdata = wd;
    bus_a.re = re; bus_a.raddr = {ra1, ra0};
  endtask

  task automatic drv_z(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                       input logic [1:0] re, input logic [3:0] ra1, input logic [3:0] ra0);
    bus_z.we = we; bus_z.waddr = wa; bus_z.wdata = wd;
    bus_z.re = re; bus_z.raddr = {ra1, ra0};
  endtask

  task automatic drv_d(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                       input logic [1:0] re, input logic [3:0] ra1, input logic [3:0] ra0);
    bus_d.we = we; bus_d.waddr = wa; bus_d.wdata = wd;
    bus_d.re = re; bus_d.raddr = {ra1, ra0};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    drv_a(1'b0, 4'd0, 16'h0, 2'b00, 4'd0, 4'd0);
    drv_z(1'b0, 4'd0, 16'h0, 2'b00, 4'd0, 4'd0);
    drv_d(1'b0, 4'd0, 16'h0, 2'b00, 4'd0, 4'd0);
    step();
    // A write and a read presented during reset are ignored.
    drv_a(1'b1, 4'd5, 16'h7777, 2'b01, 4'd0, 4'd5);
    step();
    chk("reset_rvalid", {30'd0, bus_a.rvalid}, 32'h0);
    chk("reset_rdata",  bus_a.rdata, 32'h0);
    chk("reset_werr",   {31'd0, bus_a.werr}, 32'h0);
    reset = 1'b0;

    // Read all 16 words after reset on port 0.
    for (int a = 0; a < 16; a++) begin
      drv_a(1'b0, 4'd0, 16'h0, 2'b01, 4'd0, 4'(a));
      step();
      chk($sformatf("clr_rdata_%0d", a), {16'd0, bus_a.rdata[15:0]}, 32'h0);
      chk($sformatf("clr_rvalid_%0d", a), {30'd0, bus_a.rvalid}, 32'h1);
    end

    // Write, then read back on both ports together.
    drv_a(1'b1, 4'd3, 16'hA5A5, 2'b00, 4'd0, 4'd0);
    step();
    drv_a(1'b1, 4'd15, 16'h1234, 2'b00, 4'd0, 4'd0);
    step();
    drv_a(1'b0, 4'd0, 16'h0, 2'b11, 4'd15, 4'd3);
    step();
    chk("rb_port0", {16'd0, bus_a.rdata[15:0]},  32'hA5A5);
    chk("rb_port1", {16'd0, bus_a.rdata[31:16]}, 32'h1234);
    chk("rb_rvalid", {30'd0, bus_a.rvalid}, 32'h3);

    // Idle ports: valid drops and data holds.
    drv_a(1'b0, 4'd0, 16'h0, 2'b00, 4'd0, 4'd0);
    step();
    chk("idle_rvalid", {30'd0, bus_a.rvalid}, 32'h0);
    chk("idle_hold", bus_a.rdata, 32'h1234A5A5);
    chk("idle_werr", {31'd0, bus_a.werr}, 32'h0);

    // Write-through bypass on both ports.
    drv_a(1'b1, 4'd7, 16'h1111, 2'b00, 4'd0, 4'd0);
    step();
    drv_a(1'b1, 4'd7, 16'h2222, 2'b11, 4'd7, 4'd7);
    step();
    chk("byp_data", bus_a.rdata, 32'h22222222);
    chk("byp_rvalid", {30'd0, bus_a.rvalid}, 32'h3);
    drv_a(1'b0, 4'd0, 16'h0, 2'b01, 4'd0, 4'd7);
    step();
    chk("byp_after", {16'd0, bus_a.rdata[15:0]}, 32'h2222);
    // Bypass to port 1 only, with port 0 reading a different word.
    drv_a(1'b1, 4'd9, 16'hC0DE, 2'b11, 4'd9, 4'd3);
    step();
    chk("byp_mixed", bus_a.rdata, 32'hC0DEA5A5);

    // Zero-register variant.
    drv_a(1'b0, 4'd0, 16'h0, 2'b00, 4'd0, 4'd0);
    drv_z(1'b1, 4'd0, 16'hFFFF, 2'b01, 4'd0, 4'd0);
    step();
    chk("z0_rdata", {16'd0, bus_z.rdata[15:0]}, 32'h0);
    chk("z0_rvalid", {30'd0, bus_z.rvalid}, 32'h1);
    chk("z0_werr", {31'd0, bus_z.werr}, 32'h0);
    drv_z(1'b1, 4'd5, 16'hBEEF, 2'b11, 4'd5, 4'd0);
    step();
    chk("z0_reread", {16'd0, bus_z.rdata[15:0]}, 32'h0);
    chk("z5_bypass", {16'd0, bus_z.rdata[31:16]}, 32'hBEEF);
    chk("z_werr2", {31'd0, bus_z.werr}, 32'h0);
    drv_z(1'b0, 4'd0, 16'h0, 2'b00, 4'd0, 4'd0);

    // Depth-12 variant: out-of-range writes and reads.
    drv_d(1'b1, 4'd4, 16'h5A5A, 2'b00, 4'd0, 4'd0);
    step();
    chk("d_werr_ok", {31'd0, bus_d.werr}, 32'h0);
    drv_d(1'b1, 4'd13, 16'hDEAD, 2'b00, 4'd0, 4'd0);
    step();
    chk("d_werr_13", {31'd0, bus_d.werr}, 32'h1);
    drv_d(1'b0, 4'd0, 16'h0, 2'b11, 4'd13, 4'd4);
    step();
    chk("d_werr_clear", {31'd0, bus_d.werr}, 32'h0);
    chk("d_rd_4", {16'd0, bus_d.rdata[15:0]}, 32'h5A5A);
    chk("d_rd_13", {16'd0, bus_d.rdata[31:16]}, 32'h0);
    chk("d_rvalid", {30'd0, bus_d.rvalid}, 32'h3);
    // Boundary: 11 is the last valid word and 12 the first invalid one; the
    // read of 12 carries the same address as the write but must not bypass.
    drv_d(1'b1, 4'd11, 16'h0B0B, 2'b00, 4'd0, 4'd0);
    step();
    chk("d_werr_11", {31'd0, bus_d.werr}, 32'h0);
    drv_d(1'b1, 4'd12, 16'hCCCC, 2'b11, 4'd12, 4'd11);
    step();
    chk("d_werr_12", {31'd0, bus_d.werr}, 32'h1);
    chk("d_rd_11_12", bus_d.rdata, 32'h00000B0B);
    drv_d(1'b0, 4'd0, 16'h0, 2'b00, 4'd0, 4'd0);
    step();
    chk("d_werr_pulse", {31'd0, bus_d.werr}, 32'h0);

    // Reset mid-read.
    drv_a(1'b0, 4'd0, 16'h0, 2'b01, 4'd0, 4'd3);
    step();
    chk("mr_pre_data", {16'd0, bus_a.rdata[15:0]}, 32'hA5A5);
    reset = 1'b1;
    drv_a(1'b0, 4'd0, 16'h0, 2'b00, 4'd0, 4'd0);
    step();
    chk("mr_rvalid", {30'd0, bus_a.rvalid}, 32'h0);
    chk("mr_rdata", bus_a.rdata, 32'h0);
    reset = 1'b0;
    drv_a(1'b0, 4'd0, 16'h0, 2'b11, 4'd15, 4'd3);
    step();
    chk("mr_lost", bus_a.rdata, 32'h0);
    chk("mr_rvalid2", {30'd0, bus_a.rvalid}, 32'h3);
    drv_a(1'b0, 4'd0, 16'h0, 2'b01, 4'd0, 4'd5);
    step();
    chk("mr_rst_write_ignored", {16'd0, bus_a.rdata[15:0]}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
